// File: rtl/fpu_core_pkg.sv
// Package pa_fpu: binary32 operation encoding, constants and operand unpacking
// shared by fpu_core and fpu_round_pack.
package pa_fpu;

  typedef enum logic [1:0] {
    op_add = 2'd0,
    op_sub = 2'd1,
    op_mul = 2'd2,
    op_div = 2'd3
  } e_fpu_op;

  localparam logic [31:0] QNAN    = 32'h7fc00000;
  localparam logic [31:0] POS_INF = 32'h7f800000;

  localparam int unsigned EXP_W  = 10;
  localparam int unsigned MANT_W = 48;

  localparam logic signed [EXP_W-1:0] BIAS = 10'sd127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } t_fpu_operand;

  // Subnormals get hidden bit 0 and effective exponent 1.
  function automatic t_fpu_operand unpack_operand(input logic [31:0] v);
    t_fpu_operand u;
    u.sign    = v[31];
    u.exp     = (v[30:23] == 8'd0) ? 8'd1 : v[30:23];
    u.mant    = {(v[30:23] != 8'd0), v[22:0]};
    u.is_zero = (v[30:0] == 31'd0);
    u.is_inf  = (v[30:23] == 8'hff) && (v[22:0] == 23'd0);
    u.is_nan  = (v[30:23] == 8'hff) && (v[22:0] != 23'd0);
    return u;
  endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// fpu_round_pack: normalise, denormalise to emin, round-to-nearest-even and pack
// binary32. mant_i bit 46 weighs 2^0 at biased exponent exp_i. Flags with FPU_FLAGS_EN.
module fpu_round_pack
  import pa_fpu::*;
(
  input  logic                    sign_i,
  input  logic signed [EXP_W-1:0] exp_i,
  input  logic [MANT_W-1:0]       mant_i,
  input  logic                    sticky_i,
  output logic [31:0]             result_o
`ifdef FPU_FLAGS_EN
  ,
  output logic [4:0]              flags_o
`endif
);

  localparam logic [MANT_W-1:0]       ONES     = '1;
  localparam logic signed [EXP_W-1:0] LEAD_REF = 10'sd46;

  logic [5:0]              lead;
  logic signed [EXP_W-1:0] e_norm;
  logic [EXP_W-1:0]        dn_sh;
  logic [MANT_W-1:0]       norm;
  logic [MANT_W-1:0]       den;
  logic                    tiny;
  logic                    ovf;
  logic                    guard;
  logic                    sticky;
  logic                    inc;
  logic [7:0]              e_base;
  logic [30:0]             packed_mag;

  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < MANT_W; i++) begin
      if (mant_i[i]) lead = 6'(i);
    end
    e_norm = exp_i + $signed({4'b0, lead}) - LEAD_REF;
    norm   = mant_i << (6'd47 - lead);
    tiny   = (e_norm < 10'sd1);
    ovf    = (e_norm > 10'sd254);
    dn_sh  = tiny ? $unsigned(10'sd1 - e_norm) : '0;
    den    = norm >> dn_sh;
    guard  = den[23];
    sticky = sticky_i | (|den[22:0]) | (|(norm & ~(ONES << dn_sh)));
    inc    = guard & (sticky | den[24]);
    // Hidden bit is added into the exponent field, so a rounding carry out of a
    // subnormal or out of 1.fff..f lands in the exponent naturally.
    e_base     = tiny ? 8'd0 : (e_norm[7:0] - 8'd1);
    packed_mag = {e_base, 23'd0} + {7'd0, den[47:24]} + {30'd0, inc};

    if (mant_i == '0)  result_o = {sign_i, 31'd0};
    else if (ovf)      result_o = {sign_i, POS_INF[30:0]};
    else               result_o = {sign_i, packed_mag};
  end

`ifdef FPU_FLAGS_EN
  logic nx;
  always_comb begin
    nx      = ovf | guard | sticky;
    flags_o = '0;
    if (mant_i != '0)
      flags_o = {1'b0, 1'b0, ovf | (packed_mag[30:23] == 8'hff), tiny & nx, nx};
  end
`endif

endmodule

// File: rtl/fpu_core.sv
// fpu_core: binary32 add/sub/mul with one output register stage, RNE, full subnormals.
// Optional FPU_FLAGS_EN adds the registered {NV,DZ,OF,UF,NX} fpu_flags port.
module fpu_core
  import pa_fpu::*;
(
  input  logic        clk,
  input  logic        arst,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  e_fpu_op     operation,
  input  logic        in_valid,
  output logic [31:0] ieee_packet_out,
  output logic        out_valid
`ifdef FPU_FLAGS_EN
  ,
  output logic [4:0]  fpu_flags
`endif
);

  localparam logic [MANT_W-1:0] ONES = '1;

  t_fpu_operand            ua, ub;
  logic                    b_sign_eff, eff_sub, a_is_big, is_mul, use_rp;
  logic                    x_sign, align_sticky, add_sign;
  logic [7:0]              x_exp, y_exp, align_sh;
  logic [23:0]             x_mant, y_mant;
  logic [MANT_W-1:0]       x_ext, y_ext, y_al, add_mant, mul_mant;
  logic signed [EXP_W-1:0] mul_exp;
  logic                    rp_sign, rp_sticky;
  logic signed [EXP_W-1:0] rp_exp;
  logic [MANT_W-1:0]       rp_mant;
  logic [31:0]             rp_result, special_res, result_d, result_q;
  logic                    valid_q;

  assign ua = unpack_operand(a_operand);
  assign ub = unpack_operand(b_operand);

  // Add/sub: larger magnitude is x, smaller is aligned with sticky collection.
  always_comb begin
    b_sign_eff   = ub.sign ^ (operation == op_sub);
    eff_sub      = ua.sign ^ b_sign_eff;
    a_is_big     = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
    x_sign       = a_is_big ? ua.sign : b_sign_eff;
    x_exp        = a_is_big ? ua.exp  : ub.exp;
    x_mant       = a_is_big ? ua.mant : ub.mant;
    y_exp        = a_is_big ? ub.exp  : ua.exp;
    y_mant       = a_is_big ? ub.mant : ua.mant;
    align_sh     = x_exp - y_exp;
    x_ext        = {1'b0, x_mant, 23'd0};
    y_ext        = {1'b0, y_mant, 23'd0};
    y_al         = y_ext >> align_sh;
    align_sticky = |(y_ext & ~(ONES << align_sh));
    // Lost bits borrow one unit; sticky keeps the remainder visible to rounding.
    add_mant     = eff_sub ? (x_ext - y_al - MANT_W'(align_sticky)) : (x_ext + y_al);
    add_sign     = (add_mant == '0) ? (ua.sign & b_sign_eff) : x_sign;
  end

  assign mul_mant = MANT_W'(ua.mant) * MANT_W'(ub.mant);
  assign mul_exp  = $signed({2'b0, ua.exp}) + $signed({2'b0, ub.exp}) - BIAS;

  assign is_mul    = (operation == op_mul);
  assign rp_sign   = is_mul ? (ua.sign ^ ub.sign) : add_sign;
  assign rp_exp    = is_mul ? mul_exp : $signed({2'b0, x_exp});
  assign rp_mant   = is_mul ? mul_mant : add_mant;
  assign rp_sticky = is_mul ? 1'b0 : align_sticky;

`ifdef FPU_FLAGS_EN
  logic [4:0] rp_flags, flags_d, flags_q;
  logic       nv;

  fpu_round_pack u_round_pack (
    .sign_i   (rp_sign),
    .exp_i    (rp_exp),
    .mant_i   (rp_mant),
    .sticky_i (rp_sticky),
    .result_o (rp_result),
    .flags_o  (rp_flags)
  );
`else
  fpu_round_pack u_round_pack (
    .sign_i   (rp_sign),
    .exp_i    (rp_exp),
    .mant_i   (rp_mant),
    .sticky_i (rp_sticky),
    .result_o (rp_result)
  );
`endif

  always_comb begin
    use_rp      = 1'b0;
    special_res = QNAN;
    if (operation == op_div || ua.is_nan || ub.is_nan) begin
      special_res = QNAN;
    end else if (is_mul) begin
      if ((ua.is_inf && ub.is_zero) || (ub.is_inf && ua.is_zero)) special_res = QNAN;
      else if (ua.is_inf || ub.is_inf) special_res = {ua.sign ^ ub.sign, POS_INF[30:0]};
      else use_rp = 1'b1;
    end else begin
      if (ua.is_inf && ub.is_inf && eff_sub) special_res = QNAN;
      else if (ua.is_inf)                    special_res = {ua.sign, POS_INF[30:0]};
      else if (ub.is_inf)                    special_res = {b_sign_eff, POS_INF[30:0]};
      else use_rp = 1'b1;
    end
    result_d = use_rp ? rp_result : special_res;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) result_q <= result_d;
    end
  end

`ifdef FPU_FLAGS_EN
  // Signalling NaNs raise NV; quiet NaNs propagate silently.
  always_comb begin
    nv = (operation == op_div)
       | ((a_operand[30:23] == 8'hff) & ~a_operand[22] & (a_operand[21:0] != 22'd0))
       | ((b_operand[30:23] == 8'hff) & ~b_operand[22] & (b_operand[21:0] != 22'd0))
       | (is_mul & ((ua.is_inf & ub.is_zero) | (ub.is_inf & ua.is_zero)))
       | (~is_mul & ua.is_inf & ub.is_inf & eff_sub);
    flags_d = use_rp ? rp_flags : {nv, 4'b0};
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)          flags_q <= '0;
    else if (in_valid) flags_q <= flags_d;
  end

  assign fpu_flags = flags_q;
`endif

  assign ieee_packet_out = result_q;
  assign out_valid       = valid_q;

endmodule

// File: tb/tb_fpu_core.sv
// Directed self-checking bench for fpu_core: arithmetic vectors, specials, subnormals,
// back-to-back issue, output hold and asynchronous reset.
module tb_fpu_core;
  import pa_fpu::*;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  e_fpu_op     operation = op_add;
  logic        in_valid = 1'b0;
  logic [31:0] ieee_packet_out;
  logic        out_valid;
`ifdef FPU_FLAGS_EN
  logic [4:0]  fpu_flags;
`endif

  int checks = 0;
  int errors = 0;

  fpu_core dut (
    .clk             (clk),
    .arst            (arst),
    .a_operand       (a_operand),
    .b_operand       (b_operand),
    .operation       (operation),
    .in_valid        (in_valid),
    .ieee_packet_out (ieee_packet_out),
    .out_valid       (out_valid)
`ifdef FPU_FLAGS_EN
    ,
    .fpu_flags       (fpu_flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, check the registered result just after the next posedge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input e_fpu_op op,
                        input logic [31:0] exp, input string tag);
    @(negedge clk);
    a_operand = a;
    b_operand = b;
    operation = op;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    check(tag, ieee_packet_out, exp);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    #1 arst = 1'b1;
    #2;
    check("reset_out", ieee_packet_out, 32'h0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    arst = 1'b0;

    // Consecutive run_op calls keep in_valid high: back-to-back issue.
    run_op(32'h3f800000, 32'h3f800000, op_add, 32'h40000000, "add_1p1");
    run_op(32'h41800000, 32'h42000000, op_add, 32'h42400000, "add_16p32");
    run_op(32'h3f800000, 32'h3f8ccccd, op_sub, 32'hbdccccd0, "sub_1m1p1");
    run_op(32'h3e800000, 32'h3f000000, op_sub, 32'hbe800000, "sub_q_h");
    run_op(32'h41800000, 32'h42000000, op_mul, 32'h44000000, "mul_16x32");
    run_op(32'h3e800000, 32'h3f000000, op_mul, 32'h3e000000, "mul_q_h");
    run_op(32'h007fffff, 32'h00000001, op_add, 32'h00800000, "add_sub_to_norm");
    run_op(32'h00000001, 32'h80000001, op_add, 32'h00000000, "add_sub_cancel");
    run_op(32'h00000001, 32'h40000000, op_mul, 32'h00000002, "mul_sub_x2");
    run_op(32'h00000001, 32'h00000001, op_mul, 32'h00000000, "mul_sub_uflow");
    run_op(32'h3f800000, 32'h33800000, op_add, 32'h3f800000, "add_tie_even");
    run_op(32'h3f800001, 32'h33800000, op_add, 32'h3f800002, "add_tie_odd");
    run_op(32'h3f800000, 32'h00000001, op_sub, 32'h3f800000, "sub_sticky");
    run_op(32'h80000000, 32'h80000000, op_add, 32'h80000000, "add_negzero");
    run_op(32'h7f000000, 32'h40000000, op_mul, 32'h7f800000, "mul_ovf");
    run_op(32'h7f800000, 32'hff800000, op_add, 32'h7fc00000, "add_inf_m_inf");
    run_op(32'h7f800000, 32'h00000000, op_mul, 32'h7fc00000, "mul_inf_zero");
    run_op(32'hff800000, 32'hff800000, op_mul, 32'h7f800000, "mul_ninf_ninf");
    run_op(32'h3f800000, 32'h7f800000, op_sub, 32'hff800000, "sub_fin_inf");
    run_op(32'h7fc00000, 32'h402df854, op_add, 32'h7fc00000, "add_nan");
    run_op(32'h3f800000, 32'h40000000, op_div, 32'h7fc00000, "div_unsup");
`ifdef FPU_FLAGS_EN
    check("div_flags", {27'd0, fpu_flags}, 32'h10);
`endif
    run_op(32'h00000001, 32'h80000000, op_mul, 32'h80000000, "mul_sign_zero");

    // Output holds with in_valid low while operands change.
    @(negedge clk);
    in_valid  = 1'b0;
    a_operand = 32'h40400000;
    b_operand = 32'h40400000;
    operation = op_add;
    @(posedge clk);
    #1;
    check("hold_out_1", ieee_packet_out, 32'h80000000);
    check("hold_valid_1", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("hold_out_2", ieee_packet_out, 32'h80000000);

    // Asynchronous reset mid-stream, then an op issued during reset is discarded.
    run_op(32'h41800000, 32'h42000000, op_add, 32'h42400000, "pre_reset");
    #2 arst = 1'b1;
    #1;
    check("arst_out", ieee_packet_out, 32'h0);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    a_operand = 32'h3f800000;
    b_operand = 32'h3f800000;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    check("arst_hold_out", ieee_packet_out, 32'h0);
    @(negedge clk);
    arst     = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_out", ieee_packet_out, 32'h0);
    check("post_reset_valid", {31'd0, out_valid}, 32'd0);
    run_op(32'h3f800000, 32'h3f800000, op_mul, 32'h3f800000, "recover_mul");

    @(negedge clk);
    in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
